// File: rtl/branch_sequencer.sv
// Branch/jump sequencer: time-shares the datapath ALU between branch compare and
// target calculation, then commits the next PC for one cycle.
module branch_sequencer #(
    parameter int          XLEN    = 32,
    parameter logic [3:0]  OP_ADD  = 4'd0,
    parameter logic [3:0]  OP_XOR  = 4'd4,
    parameter logic [3:0]  OP_SLT  = 4'd2,
    parameter logic [3:0]  OP_SLTU = 4'd3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_kind,
    input  logic [2:0]      req_cmp,
    input  logic [XLEN-1:0] req_pc,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [XLEN-1:0] req_imm,
    input  logic            abort,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    output logic            pc_we,
    output logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] link_val,
    output logic            taken,
    output logic            flush_out,
    output logic            misalign,
    output logic            busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMP    = 2'd1,
        ST_TGT    = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [1:0]      KIND_BR   = 2'b00;
    localparam logic [1:0]      KIND_JAL  = 2'b01;
    localparam logic [1:0]      KIND_JALR = 2'b10;

    state_t            state_q, state_d;
    logic [1:0]        kind_q, kind_d;
    logic [2:0]        cmp_q, cmp_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [XLEN-1:0]   rs2_q, rs2_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [XLEN-1:0]   pc4_q, pc4_d;
    logic              pc_we_q, pc_we_d;
    logic              misalign_q, misalign_d;
    logic              taken_q, taken_d;
    logic [XLEN-1:0]   pc_next_q, pc_next_d;
    logic [XLEN-1:0]   link_q, link_d;
    logic [XLEN-1:0]   pc4_s;
    logic [XLEN-1:0]   target_s;
    logic              flag_s;
    logic              zero_s;

    // Private adder so the link value never needs an ALU slot.
    assign pc4_s  = req_pc + PC_STEP;
    assign zero_s = (alu_result == '0);

    // Next-state, request latching, ALU steering and commit-value computation.
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        cmp_d      = cmp_q;
        pc_d       = pc_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        imm_d      = imm_q;
        pc4_d      = pc4_q;
        pc_we_d    = 1'b0;
        misalign_d = 1'b0;
        taken_d    = 1'b0;
        pc_next_d  = '0;
        link_d     = '0;
        alu_op     = OP_ADD;
        alu_a      = '0;
        alu_b      = '0;
        flag_s     = 1'b0;
        target_s   = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    kind_d = req_kind;
                    cmp_d  = req_cmp;
                    pc_d   = req_pc;
                    rs1_d  = req_rs1;
                    rs2_d  = req_rs2;
                    imm_d  = req_imm;
                    pc4_d  = pc4_s;
                    case (req_kind)
                        KIND_BR:   state_d = ST_CMP;
                        KIND_JAL:  state_d = ST_TGT;
                        KIND_JALR: state_d = ST_TGT;
                        default: begin
                            // Reserved kind commits straight away as not taken.
                            state_d   = ST_COMMIT;
                            pc_we_d   = 1'b1;
                            pc_next_d = pc4_s;
                            link_d    = pc4_s;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMP: begin
                alu_a = rs1_q;
                alu_b = rs2_q;
                case (cmp_q)
                    3'b000: begin alu_op = OP_XOR;  flag_s = zero_s;         end
                    3'b001: begin alu_op = OP_XOR;  flag_s = ~zero_s;        end
                    3'b100: begin alu_op = OP_SLT;  flag_s = alu_result[0];  end
                    3'b101: begin alu_op = OP_SLT;  flag_s = ~alu_result[0]; end
                    3'b110: begin alu_op = OP_SLTU; flag_s = alu_result[0];  end
                    3'b111: begin alu_op = OP_SLTU; flag_s = ~alu_result[0]; end
                    default: begin alu_op = OP_XOR; flag_s = 1'b0;           end
                endcase
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (flag_s) begin
                    state_d = ST_TGT;
                end else begin
                    state_d   = ST_COMMIT;
                    pc_we_d   = 1'b1;
                    pc_next_d = pc4_q;
                    link_d    = pc4_q;
                end
            end
            ST_TGT: begin
                alu_op = OP_ADD;
                alu_b  = imm_q;
                if (kind_q == KIND_JALR) begin
                    alu_a    = rs1_q;
                    target_s = {alu_result[XLEN-1:1], 1'b0};
                end else begin
                    alu_a    = pc_q;
                    target_s = alu_result;
                end
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d    = ST_COMMIT;
                    taken_d    = 1'b1;
                    pc_next_d  = target_s;
                    link_d     = pc4_q;
                    misalign_d = target_s[1];
                    pc_we_d    = ~target_s[1];
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State, request latches and registered commit outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            kind_q     <= 2'b00;
            cmp_q      <= 3'b000;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            pc4_q      <= '0;
            pc_we_q    <= 1'b0;
            misalign_q <= 1'b0;
            taken_q    <= 1'b0;
            pc_next_q  <= '0;
            link_q     <= '0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            cmp_q      <= cmp_d;
            pc_q       <= pc_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            imm_q      <= imm_d;
            pc4_q      <= pc4_d;
            pc_we_q    <= pc_we_d;
            misalign_q <= misalign_d;
            taken_q    <= taken_d;
            pc_next_q  <= pc_next_d;
            link_q     <= link_d;
        end
    end

    // An abort arriving in the commit cycle must still cancel the strobe.
    assign pc_we     = pc_we_q & ~abort;
    assign misalign  = misalign_q & ~abort;
    assign flush_out = pc_we & taken_q;
    assign taken     = taken_q;
    assign pc_next   = pc_next_q;
    assign link_val  = link_q;
    assign busy      = (state_q != ST_IDLE);
    assign req_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer with a behavioural ALU on the shared port.
module tb_branch_sequencer;

    logic        clk, rst_n;
    logic        req_valid, req_ready, abort;
    logic [1:0]  req_kind;
    logic [2:0]  req_cmp;
    logic [31:0] req_pc, req_rs1, req_rs2, req_imm;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        pc_we, taken, flush_out, misalign, busy;
    logic [31:0] pc_next, link_val;

    int total = 0;
    int passed = 0;
    logic [3:0] op_c1, op_c2;

    typedef struct {
        logic        misalign;
        logic        taken;
        logic [31:0] pc_next;
        logic [31:0] link;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    branch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_cmp(req_cmp), .req_pc(req_pc), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_imm(req_imm), .abort(abort), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .pc_we(pc_we),
        .pc_next(pc_next), .link_val(link_val), .taken(taken), .flush_out(flush_out),
        .misalign(misalign), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            4'd0:    alu_result = alu_a + alu_b;
            4'd4:    alu_result = alu_a ^ alu_b;
            4'd2:    alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'd3:    alu_result = {31'd0, alu_a < alu_b};
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    function automatic exp_t model(input logic [1:0] kind, input logic [2:0] cmp,
                                   input logic [31:0] pc, input logic [31:0] rs1,
                                   input logic [31:0] rs2, input logic [31:0] imm);
        exp_t e;
        logic f;
        logic [31:0] tgt;
        e.link = pc + 32'd4;
        f = 1'b0;
        tgt = pc + imm;
        case (kind)
            2'b00: begin
                case (cmp)
                    3'b000: f = (rs1 == rs2);
                    3'b001: f = (rs1 != rs2);
                    3'b100: f = ($signed(rs1) < $signed(rs2));
                    3'b101: f = !($signed(rs1) < $signed(rs2));
                    3'b110: f = (rs1 < rs2);
                    3'b111: f = !(rs1 < rs2);
                    default: f = 1'b0;
                endcase
                e.lat = f ? 3 : 2;
            end
            2'b01: begin f = 1'b1; e.lat = 2; end
            2'b10: begin f = 1'b1; e.lat = 2; tgt = (rs1 + imm) & 32'hFFFF_FFFE; end
            default: begin f = 1'b0; e.lat = 1; end
        endcase
        e.taken    = f;
        e.pc_next  = f ? tgt : pc + 32'd4;
        e.misalign = f & tgt[1];
        return e;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
    task automatic send(input logic [1:0] kind, input logic [2:0] cmp, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input bit expect_commit, input bit with_abort);
        total++;
        if (req_ready !== 1'b1) $display("FAIL ready_before_send: got %b want 1", req_ready);
        else passed++;
        req_valid = 1'b1; req_kind = kind; req_cmp = cmp; req_pc = pc;
        req_rs1 = rs1; req_rs2 = rs2; req_imm = imm; abort = with_abort;
        if (expect_commit) sb_q.push_back(model(kind, cmp, pc, rs1, rs2, imm));
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_commit(input string name);
        exp_t e;
        bit found;
        int lat;
        e = sb_q.pop_front();
        found = 1'b0;
        lat = 0;
        for (int c = 1; c <= 8 && !found; c++) begin
            if (c == 1) op_c1 = alu_op;
            if (c == 2) op_c2 = alu_op;
            if (pc_we || misalign) begin
                found = 1'b1;
                lat = c;
            end else begin
                @(negedge clk);
            end
        end
        total++;
        if (!found) begin
            $display("FAIL %s_timeout: no strobe within 8 cycles", name);
            return;
        end
        passed++;
        total++;
        if (lat != e.lat) $display("FAIL %s_latency: got %0d want %0d", name, lat, e.lat);
        else passed++;
        total++;
        if ({pc_we, misalign, taken, flush_out} !== {~e.misalign, e.misalign, e.taken, e.taken & ~e.misalign})
            $display("FAIL %s_flags: got we/mis/tk/fl=%b%b%b%b want %b%b%b%b", name,
                     pc_we, misalign, taken, flush_out,
                     ~e.misalign, e.misalign, e.taken, e.taken & ~e.misalign);
        else passed++;
        total++;
        if (link_val !== e.link) $display("FAIL %s_link: got %h want %h", name, link_val, e.link);
        else passed++;
        if (!e.misalign) begin
            total++;
            if (pc_next !== e.pc_next) $display("FAIL %s_pc_next: got %h want %h", name, pc_next, e.pc_next);
            else passed++;
        end
        @(negedge clk);
        total++;
        if ({pc_we, misalign, busy, req_ready} !== 4'b0001)
            $display("FAIL %s_after: got we/mis/busy/rdy=%b%b%b%b want 0001", name,
                     pc_we, misalign, busy, req_ready);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; abort = 1'b0; req_kind = 2'b00; req_cmp = 3'b000;
        req_pc = 32'd0; req_rs1 = 32'd0; req_rs2 = 32'd0; req_imm = 32'd0;
        #12;
        total++;
        if ({pc_we, taken, flush_out, misalign, busy, pc_next, link_val, alu_op, alu_a, alu_b} !== 137'd0)
            $display("FAIL reset_outputs: got we=%b tk=%b pcn=%h link=%h op=%h a=%h b=%h busy=%b want all 0",
                     pc_we, taken, pc_next, link_val, alu_op, alu_a, alu_b, busy);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_beq();
        send(2'b00, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 1'b1, 1'b0);
        wait_commit("beq");
        total++;
        if ({op_c1, op_c2} !== {4'd4, 4'd0})
            $display("FAIL beq_alu_ops: got %0d,%0d want 4,0", op_c1, op_c2);
        else passed++;
    endtask

    task automatic test_blt_bltu();
        send(2'b00, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 1'b0);
        wait_commit("blt");
        send(2'b00, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 1'b0);
        wait_commit("bltu");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic [2:0] f;
            f = 3'(i);
            send(2'b00, f, 32'h1000 + 32'(i * 16), 32'd3, 32'd7, 32'h80, 1'b1, 1'b0);
            wait_commit("funct3_sweep");
        end
    endtask

    task automatic test_jalr();
        send(2'b10, 3'b000, 32'h40, 32'h1003, 32'h4, 32'h0, 1'b1, 1'b0);
        wait_commit("jalr_misalign");
        send(2'b10, 3'b000, 32'h80, 32'h1001, 32'h10, 32'h0, 1'b1, 1'b0);
        wait_commit("jalr_aligned");
    endtask

    task automatic test_jal_wrap();
        send(2'b01, 3'b000, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'h20, 1'b1, 1'b0);
        total++;
        if (req_ready !== 1'b0) $display("FAIL jal_ready_busy: got %b want 0", req_ready);
        else passed++;
        wait_commit("jal_wrap");
        send(2'b11, 3'b000, 32'h500, 32'h1, 32'h2, 32'h3, 1'b1, 1'b0);
        wait_commit("reserved");
    endtask

    task automatic test_abort();
        bit seen;
        seen = 1'b0;
        send(2'b00, 3'b001, 32'h600, 32'd1, 32'd2, 32'h10, 1'b0, 1'b0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if ({req_ready, busy} !== 2'b10) $display("FAIL abort_tgt_idle: got rdy/busy=%b%b want 10", req_ready, busy);
        else passed++;
        for (int c = 0; c < 4; c++) begin
            if (pc_we || misalign) seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (seen) $display("FAIL abort_tgt_strobe: got strobe=1 want 0");
        else passed++;
        send(2'b00, 3'b000, 32'h700, 32'd9, 32'd8, 32'h10, 1'b1, 1'b0);
        wait_commit("after_abort");
        // Abort landing in the commit cycle.
        send(2'b11, 3'b000, 32'h800, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        abort = 1'b1;
        #1;
        total++;
        if ({pc_we, flush_out, busy} !== 3'b001)
            $display("FAIL abort_commit: got we/fl/busy=%b%b%b want 001", pc_we, flush_out, busy);
        else passed++;
        @(negedge clk);
        abort = 1'b0;
        #1;
        total++;
        if ({pc_we, busy} !== 2'b00) $display("FAIL abort_commit_after: got we/busy=%b%b want 00", pc_we, busy);
        else passed++;
        @(negedge clk);
        // Abort while idle is ignored and the same-cycle request is taken.
        send(2'b00, 3'b101, 32'h900, 32'd4, 32'd4, 32'h24, 1'b1, 1'b1);
        wait_commit("abort_idle");
    endtask

    task automatic test_reset_mid();
        send(2'b00, 3'b000, 32'hA00, 32'd1, 32'd1, 32'h10, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({pc_we, taken, flush_out, misalign, busy, pc_next, link_val, alu_op, alu_a, alu_b, req_ready} !== 138'd1)
            $display("FAIL reset_mid: got we=%b busy=%b op=%h a=%h b=%h rdy=%b want zeros, rdy=1",
                     pc_we, busy, alu_op, alu_a, alu_b, req_ready);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(2'b00, 3'b010, 32'hB00, 32'd7, 32'd7, 32'h8, 1'b1, 1'b0);
        wait_commit("funct3_010");
    endtask

    initial begin
        test_reset();
        test_beq();
        test_blt_bltu();
        test_back_to_back();
        test_jalr();
        test_jal_wrap();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
